// File: rtl/pool_flatten_if.sv
// Layer-memory bus plus start/status handshake between the flatten block and its system.
// slave = the flatten block, master = the system/memory side.
interface pool_flatten_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 12
);
    logic              start;
    logic              mode;
    logic              busy;
    logic              done;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic [2:0]        csel;

    modport slave (
        input  start, mode, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport master (
        output start, mode, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/pool_flatten.sv
// Reads the two pooled kernel maps and writes them interleaved (or k0 only) into the flatten memory.
// Every output is registered; each state's port view is loaded on the edge that enters it.
module pool_flatten #(
    parameter int         DATA_W   = 20,
    parameter int         ADDR_W   = 12,
    parameter int         NPIX     = 1024,
    parameter logic [2:0] SRC0_SEL = 3'h3,
    parameter logic [2:0] SRC1_SEL = 3'h4,
    parameter logic [2:0] DST_SEL  = 3'h5
) (
    input  logic         clk,
    input  logic         reset,
    pool_flatten_if.slave bus
);
    localparam int IDX_W = $clog2(NPIX);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, FIN} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  n_q;
    logic              mode_q;
    logic              busy_q;
    logic              done_q;
    logic              crd_q;
    logic              cwr_q;
    logic [2:0]        csel_q;
    logic [ADDR_W-1:0] caddr_rd_q;
    logic [ADDR_W-1:0] caddr_wr_q;
    logic [DATA_W-1:0] cdata_wr_q;

    logic [IDX_W-1:0]  n_inc_d;
    logic              last_d;

    assign n_inc_d = n_q + 1'b1;
    assign last_d  = (n_q == IDX_W'(NPIX - 1));

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crd      = crd_q;
    assign bus.cwr      = cwr_q;
    assign bus.csel     = csel_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 3'h0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
        end else begin
            // Strobes, select and write data fall back to idle unless the next state drives them.
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 3'h0;
            cdata_wr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= RD0;
                        mode_q     <= bus.mode;
                        n_q        <= '0;
                        busy_q     <= 1'b1;
                        crd_q      <= 1'b1;
                        csel_q     <= SRC0_SEL;
                        caddr_rd_q <= '0;
                    end
                end
                RD0: begin
                    state_q    <= WR0;
                    cwr_q      <= 1'b1;
                    csel_q     <= DST_SEL;
                    cdata_wr_q <= bus.cdata_rd;
                    caddr_wr_q <= mode_q ? ADDR_W'(n_q) : ADDR_W'({n_q, 1'b0});
                end
                WR0: begin
                    if (!mode_q) begin
                        state_q    <= RD1;
                        crd_q      <= 1'b1;
                        csel_q     <= SRC1_SEL;
                        caddr_rd_q <= ADDR_W'(n_q);
                    end else if (!last_d) begin
                        state_q    <= RD0;
                        n_q        <= n_inc_d;
                        crd_q      <= 1'b1;
                        csel_q     <= SRC0_SEL;
                        caddr_rd_q <= ADDR_W'(n_inc_d);
                    end else begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                RD1: begin
                    state_q    <= WR1;
                    cwr_q      <= 1'b1;
                    csel_q     <= DST_SEL;
                    cdata_wr_q <= bus.cdata_rd;
                    caddr_wr_q <= ADDR_W'({n_q, 1'b1});
                end
                WR1: begin
                    if (!last_d) begin
                        state_q    <= RD0;
                        n_q        <= n_inc_d;
                        crd_q      <= 1'b1;
                        csel_q     <= SRC0_SEL;
                        caddr_rd_q <= ADDR_W'(n_inc_d);
                    end else begin
                        state_q <= FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    n_q     <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_flatten.sv
// Randomized bench: memory model on the bus, expected-write queue built from the flatten rule,
// and a per-cycle compare/protocol process.
module tb_pool_flatten;
    localparam int DW   = 20;
    localparam int AW   = 12;
    localparam int NPIX = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pool_flatten_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    pool_flatten dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DW-1:0] k0 [NPIX];
    logic [DW-1:0] k1 [NPIX];
    logic [DW-1:0] dst [2*NPIX];
    logic [DW-1:0] exp_dst [2*NPIX];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t exp_q[$];

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int busy_cnt = 0;
    int exp_busy = 0;
    int wr_cnt   = 0;
    int exp_wr   = 0;
    bit prev_cwr = 1'b0;
    bit prev_done = 1'b0;
    logic [AW-1:0] last_wr_addr = '0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Asynchronous-read layer memories, synchronous write into the flatten memory.
    assign bus.cdata_rd = (bus.crd && bus.csel == 3'h3) ? k0[bus.caddr_rd[9:0]] :
                          (bus.crd && bus.csel == 3'h4) ? k1[bus.caddr_rd[9:0]] : '0;

    always @(posedge clk)
        if (bus.cwr && bus.csel == 3'h5) dst[bus.caddr_wr[10:0]] = bus.cdata_wr;

    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt  = 0;
            wr_cnt    = 0;
            prev_cwr  = 1'b0;
            prev_done = 1'b0;
        end else begin
            chk(!(bus.crd && bus.cwr), "crd_cwr_exclusive", 32'({bus.crd, bus.cwr}), 32'h1);
            if (bus.crd)
                chk(bus.csel == 3'h3 || bus.csel == 3'h4, "csel_on_read", 32'(bus.csel), 32'h3);
            if (bus.cwr) begin
                chk(bus.csel == 3'h5, "csel_on_write", 32'(bus.csel), 32'h5);
                wr_cnt++;
                last_wr_addr = bus.caddr_wr;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", 32'(bus.caddr_wr), 32'h0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk(bus.caddr_wr == e.a, "wr_addr", 32'(bus.caddr_wr), 32'(e.a));
                    chk(bus.cdata_wr == e.d, "wr_data", 32'(bus.cdata_wr), 32'(e.d));
                end
            end else begin
                chk(bus.cdata_wr == '0, "cdata_wr_zero_idle", 32'(bus.cdata_wr), 32'h0);
            end
            if (!bus.crd && !bus.cwr)
                chk(bus.csel == 3'h0, "csel_idle", 32'(bus.csel), 32'h0);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                chk(prev_cwr, "done_after_last_write", 32'(prev_cwr), 32'h1);
                chk(!prev_done, "done_single_pulse", 32'(prev_done), 32'h0);
                chk(!bus.busy, "busy_low_in_fin", 32'(bus.busy), 32'h0);
                chk(busy_cnt == exp_busy, "busy_cycles", 32'(busy_cnt), 32'(exp_busy));
                chk(wr_cnt == exp_wr, "write_count", 32'(wr_cnt), 32'(exp_wr));
                busy_cnt = 0;
                wr_cnt   = 0;
            end
            prev_cwr  = bus.cwr;
            prev_done = bus.done;
        end
    end

    // Expected writes from the flatten rule: interleave k0/k1, or k0 copied densely.
    task automatic push_transfer(input bit m);
        for (int n = 0; n < NPIX; n++) begin
            if (!m) begin
                exp_q.push_back('{AW'(2*n), k0[n]});
                exp_q.push_back('{AW'(2*n+1), k1[n]});
                exp_dst[2*n]   = k0[n];
                exp_dst[2*n+1] = k1[n];
            end else begin
                exp_q.push_back('{AW'(n), k0[n]});
                exp_dst[n] = k0[n];
            end
        end
        exp_busy = m ? 2*NPIX : 4*NPIX;
        exp_wr   = m ? NPIX : 2*NPIX;
    endtask

    task automatic fill_sentinel();
        for (int i = 0; i < 2*NPIX; i++) begin
            dst[i]     = 20'h5A5A5;
            exp_dst[i] = 20'h5A5A5;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) begin
            k0[i] = DW'($urandom);
            k1[i] = DW'($urandom);
        end
    endtask

    task automatic check_dst(input string nm);
        int bad = 0;
        for (int i = 0; i < 2*NPIX; i++)
            if (dst[i] !== exp_dst[i]) bad++;
        chk(bad == 0, nm, 32'(bad), 32'h0);
    endtask

    task automatic pulse_start(input bit m);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 1'($urandom);
    endtask

    task automatic wait_done();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.done && c < 10000);
        if (!bus.done) chk(1'b0, "done_timeout", 32'(c), 32'h0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk(bus.busy == 0 && bus.done == 0, "reset_busy_done", 32'({bus.busy, bus.done}), 32'h0);
        chk(bus.crd == 0 && bus.cwr == 0, "reset_crd_cwr", 32'({bus.crd, bus.cwr}), 32'h0);
        chk(bus.csel == 0, "reset_csel", 32'(bus.csel), 32'h0);
        chk(bus.caddr_rd == 0 && bus.caddr_wr == 0, "reset_addr", 32'({bus.caddr_rd, bus.caddr_wr}), 32'h0);
        chk(bus.cdata_wr == 0, "reset_cdata_wr", 32'(bus.cdata_wr), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Ramp data, interleave mode
        for (int n = 0; n < NPIX; n++) begin
            k0[n] = DW'(n);
            k1[n] = 20'h80000 | DW'(n);
        end
        fill_sentinel();
        push_transfer(1'b0);
        pulse_start(1'b0);
        chk(bus.busy && bus.crd && bus.caddr_rd == 0, "first_rd0", 32'({bus.busy, bus.crd, bus.caddr_rd}), 32'h3000);
        wait_done();
        @(negedge clk);
        chk(dst[0] == 20'h00000, "ramp_dst0", 32'(dst[0]), 32'h00000);
        chk(dst[1] == 20'h80000, "ramp_dst1", 32'(dst[1]), 32'h80000);
        chk(dst[2046] == 20'h003FF, "ramp_dst2046", 32'(dst[2046]), 32'h003FF);
        chk(dst[2047] == 20'h803FF, "ramp_dst2047", 32'(dst[2047]), 32'h803FF);
        check_dst("ramp_dst_all");

        // Copy-k0 mode with inverted ramp; upper half must stay untouched
        for (int n = 0; n < NPIX; n++) k0[n] = ~DW'(n);
        fill_sentinel();
        push_transfer(1'b1);
        pulse_start(1'b1);
        wait_done();
        @(negedge clk);
        chk(dst[0] == 20'hFFFFF, "copy_dst0", 32'(dst[0]), 32'hFFFFF);
        chk(dst[1023] == 20'hFFC00, "copy_dst1023", 32'(dst[1023]), 32'hFFC00);
        chk(dst[1024] == 20'h5A5A5, "copy_untouched", 32'(dst[1024]), 32'h5A5A5);
        check_dst("copy_dst_all");

        // Random data, start re-pulsed mid-transfer
        fill_random();
        fill_sentinel();
        push_transfer(1'b0);
        pulse_start(1'b0);
        repeat (97) @(negedge clk);
        pulse_start(1'b1);
        wait_done();
        repeat (5) @(negedge clk);
        chk(!bus.busy, "no_requeue_busy", 32'(bus.busy), 32'h0);
        chk(exp_q.size() == 0, "repulse_queue_empty", 32'(exp_q.size()), 32'h0);
        check_dst("repulse_dst_all");

        // Start held high: back-to-back transfers with one IDLE cycle between
        fill_random();
        fill_sentinel();
        push_transfer(1'b0);
        push_transfer(1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        wait_done();
        @(negedge clk);
        chk(!bus.busy && !bus.crd, "held_idle_gap", 32'({bus.busy, bus.crd}), 32'h0);
        @(negedge clk);
        chk(bus.busy && bus.crd && bus.caddr_rd == 0, "held_restart", 32'({bus.busy, bus.crd, bus.caddr_rd}), 32'h3000);
        bus.start = 1'b0;
        wait_done();
        @(negedge clk);
        chk(exp_q.size() == 0, "held_queue_empty", 32'(exp_q.size()), 32'h0);
        check_dst("held_dst_all");

        // Reset during the WR1 cycle of n=500, then a full clean transfer
        fill_random();
        fill_sentinel();
        push_transfer(1'b0);
        pulse_start(1'b0);
        begin
            int c = 0;
            while (!(bus.cwr && bus.caddr_wr == 12'd1001) && c < 6000) begin
                @(negedge clk);
                c++;
            end
            chk(bus.cwr && bus.caddr_wr == 12'd1001, "reach_n500_wr1", 32'(bus.caddr_wr), 32'd1001);
        end
        reset = 1'b0;
        #1;
        chk({bus.busy, bus.done, bus.crd, bus.cwr} == 4'b0, "abort_strobes", 32'({bus.busy, bus.done, bus.crd, bus.cwr}), 32'h0);
        chk(bus.csel == 0 && bus.caddr_rd == 0 && bus.caddr_wr == 0 && bus.cdata_wr == 0,
            "abort_bus", 32'(bus.caddr_wr), 32'h0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        fill_sentinel();
        push_transfer(1'b0);
        pulse_start(1'b0);
        chk(bus.crd && bus.caddr_rd == 0 && bus.csel == 3'h3, "restart_at_zero", 32'(bus.caddr_rd), 32'h0);
        wait_done();
        @(negedge clk);
        check_dst("restart_dst_all");

        // Extreme values
        for (int n = 0; n < NPIX; n++) begin
            k0[n] = 20'hFFFFF;
            k1[n] = 20'h00000;
        end
        fill_sentinel();
        push_transfer(1'b0);
        pulse_start(1'b0);
        wait_done();
        @(negedge clk);
        chk(last_wr_addr == 12'd2047, "last_write_addr", 32'(last_wr_addr), 32'd2047);
        chk(dst[2046] == 20'hFFFFF, "extreme_even", 32'(dst[2046]), 32'hFFFFF);
        chk(dst[2047] == 20'h00000, "extreme_odd", 32'(dst[2047]), 32'h00000);
        check_dst("extreme_dst_all");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
